// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffered hex value, anode ghost guard and optional leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        update,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic        value_pending,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] SLOT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // True when digit idx (>0) and every more-significant scanned nibble are zero.
    function automatic logic lead_zero(input logic [31:0] v, input logic [2:0] idx);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nz = nz | ((i >= int'(idx)) && (|v[4*i +: 4]));
        end
        return (idx != 3'd0) && !nz;
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [7:0]      act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic            pend_q, pend_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            fd_q, fd_d;
    logic            slot_end_s, frame_end_s, transfer_s;
    logic [3:0]      nib_s;

    assign slot_end_s  = (presc_q == SLOT_LAST);
    assign frame_end_s = (state_q == ST_DRIVE) && slot_end_s && (idx_q == LAST_DIGIT);
    assign transfer_s  = pend_q && (frame_end_s || (state_q == ST_IDLE));

    // Scan FSM next-state: prescaler and digit stepping.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = ST_IDLE;
            presc_d = PRESC_ZERO;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GUARD;
                    presc_d = PRESC_ZERO;
                    idx_d   = 3'd0;
                end
                ST_GUARD: begin
                    presc_d = presc_q + PRESC_ONE;
                    state_d = (presc_d >= GUARD_END) ? ST_DRIVE : ST_GUARD;
                end
                ST_DRIVE: begin
                    if (slot_end_s) begin
                        presc_d = PRESC_ZERO;
                        idx_d   = (idx_q == LAST_DIGIT) ? 3'd0 : idx_q + 3'd1;
                        state_d = ST_GUARD;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                        state_d = ST_DRIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = PRESC_ZERO;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // Double buffer: old pending moves to active before a coincident update overwrites pending.
    always_comb begin
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        if (transfer_s) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pend_d    = 1'b0;
        end else begin
            pend_d    = pend_q;
        end
        if (update) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_d     = 1'b1;
        end else begin
            pend_val_d = pend_val_q;
        end
    end

    // Output decode from next state so registered outputs line up with the scan registers.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        nib_s = act_val_d[{idx_d, 2'b00} +: 4];
        fd_d  = (state_d != ST_IDLE) && (presc_d == PRESC_ZERO) && (idx_d == 3'd0);
        if (state_d == ST_DRIVE) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = (lz_en && lead_zero(act_val_d, idx_d)) ? 7'h7F : hex_to_seg(nib_s);
            dp_d  = ~act_dp_d[idx_d];
        end else begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= PRESC_ZERO;
            idx_q      <= 3'd0;
            act_val_q  <= 32'h0000_0000;
            act_dp_q   <= 8'h00;
            pend_val_q <= 32'h0000_0000;
            pend_dp_q  <= 8'h00;
            pend_q     <= 1'b0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign value_pending = pend_q;
    assign seg           = seg_q;
    assign dp            = dp_q;
    assign an            = an_q;
    assign digit_idx     = idx_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a slot/frame arithmetic model queues the
// expected display state per clock edge; a monitor pops and compares every cycle.
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        update = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic        lz_en = 1'b0;
    logic        value_pending;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [2:0]  digit_idx;
    logic        frame_done;

    sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .update(update), .value(value),
        .dp_in(dp_in), .lz_en(lz_en), .value_pending(value_pending), .seg(seg),
        .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       fd;
        logic       vp;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reference model: m_t counts cycles since the start of slot 0 while running.
    bit          m_on;
    int          m_t;
    bit          m_pend;
    logic [31:0] m_pv, m_av;
    logic [7:0]  m_pd, m_ad;

    task automatic model_reset();
        m_on = 0; m_t = 0; m_pend = 0;
        m_pv = 32'h0; m_av = 32'h0; m_pd = 8'h0; m_ad = 8'h0;
    endtask

    // Apply inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit en, input bit upd, input logic [31:0] v,
                        input logic [7:0] d, input bit lz);
        bit boundary;
        int pos, dig;
        longint upper;
        exp_t e;
        @(negedge clk);
        enable = en; update = upd; value = v; dp_in = d; lz_en = lz;
        boundary = m_on && (m_t == FRAME - 1);
        if (m_pend && (boundary || !m_on)) begin
            m_av = m_pv; m_ad = m_pd; m_pend = 0;
        end
        if (upd) begin
            m_pv = v; m_pd = d; m_pend = 1;
        end
        if (!en) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
        pos = m_t % RD;
        dig = m_t / RD;
        e.vp  = m_pend;
        e.idx = m_on ? 3'(dig) : 3'd0;
        e.fd  = m_on && (m_t == 0);
        if (m_on && pos >= GD) begin
            upper = (longint'(m_av) & ((64'd1 << (4 * ND)) - 64'd1)) >> (4 * dig);
            e.an  = 8'(255 - (1 << dig));
            e.seg = (lz && dig > 0 && upper == 0) ? 7'h7F : seg_tab[(m_av >> (4 * dig)) & 32'hF];
            e.dp  = ~m_ad[dig];
        end else begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_run(input int n, input bit lz);
        for (int k = 0; k < n; k++) step(1, 0, 32'h0, 8'h0, lz);
    endtask

    task automatic chk_reset(input string nm);
        n_tests++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 3'd0 ||
            frame_done !== 1'b0 || value_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got an=%h seg=%b dp=%b idx=%0d fd=%b vp=%b, want an=ff seg=1111111 dp=1 idx=0 fd=0 vp=0",
                     nm, an, seg, dp, digit_idx, frame_done, value_pending);
        end
    endtask

    task automatic chk_cond(input string nm, input bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: model never reached the required scan position within budget", nm);
        end
    endtask

    // Monitor: compare every cycle the driver has queued an expectation for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (an !== e.an || seg !== e.seg || dp !== e.dp || digit_idx !== e.idx ||
                    frame_done !== e.fd || value_pending !== e.vp) begin
                    n_fail++;
                    $display("FAIL scan_cycle t=%0t: got an=%h seg=%b dp=%b idx=%0d fd=%b vp=%b, want an=%h seg=%b dp=%b idx=%0d fd=%b vp=%b",
                             $time, an, seg, dp, digit_idx, frame_done, value_pending,
                             e.an, e.seg, e.dp, e.idx, e.fd, e.vp);
                end
            end
        end
    end

    initial begin
        int k;
        logic [31:0] rv;
        model_reset();
        #1 rst = 1'b1;
        #1 chk_reset("power_on_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle buffers: guard then E,D,B,7 anodes, zeros shown, frame_done every 16.
        idle_run(40, 0);

        // Mid-frame update; shown from next frame.
        step(1, 1, 32'h0000_00A8, 8'b0000_0010, 0);
        idle_run(40, 0);

        // Same value with leading-zero blanking.
        idle_run(40, 1);

        // Update on the exact boundary edge while an earlier one is pending.
        step(1, 1, 32'h0000_1234, 8'b0000_0001, 0);
        k = 0;
        while (!(m_on && m_t == FRAME - 1) && k < 64) begin
            idle_run(1, 0);
            k++;
        end
        chk_cond("boundary_search", m_on && m_t == FRAME - 1);
        step(1, 1, 32'h0000_0F0E, 8'b0000_1000, 0);
        idle_run(40, 0);

        // Drop enable mid-DRIVE on digit 2, then re-enable.
        k = 0;
        while (!(m_on && m_t == 2 * RD + 2) && k < 64) begin
            idle_run(1, 0);
            k++;
        end
        chk_cond("digit2_search", m_on && m_t == 2 * RD + 2);
        for (int j = 0; j < 3; j++) step(0, 0, 32'h0, 8'h0, 0);
        idle_run(20, 0);

        // Randomized traffic.
        for (int j = 0; j < 300; j++) begin
            rv = $urandom();
            rv = rv >> (4 * $urandom_range(0, 8));
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, rv,
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-slot, then the active buffer must read back as zero.
        step(1, 1, 32'h0000_5678, 8'hFF, 0);
        idle_run(20, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        enable = 1'b0; update = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        idle_run(30, 0);

        @(posedge clk);
        #4;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's common-anode 8-digit seven-segment display (score/level readout).
- Holds a double-buffered 32-bit hex value and steps one digit per refresh slot.
- Each digit is decoded with the team's active-low abcdefg hex decoder, with anode ghost-guard and optional leading-zero blanking.
- Sits between game/score logic and the display pins.

Parameters:
- NUM_DIGITS, 8: digits scanned, legal 1..8; anodes at or above NUM_DIGITS are held off.
- REFRESH_DIV, 100000: clk cycles per digit slot, at least 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; legal 1..REFRESH_DIV-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  display on; when 0, display is dark and the scanner is held.
- update  in  1  one-cycle strobe; capture value/dp_in into the pending buffer.
- value  in  32  digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  8  decimal point per digit, 1 = lit.
- lz_en  in  1  leading-zero blanking enable.
- value_pending  out  1  pending buffer holds data not yet displayed.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  anode enables, active-low.
- digit_idx  out  3  index of the current slot's digit.
- frame_done  out  1  one-cycle pulse, first cycle of each digit-0 slot.

Behaviour:
- All outputs registered; seg/dp/an change on the same edge.
- Reset values (async): an=8'hFF, seg=7'h7F, dp=1, digit_idx=0, frame_done=0, value_pending=0. Active and pending buffers cleared to 0; prescaler cleared to 0.
- Decode is fixed to the team decoder codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank=1111111.
- FSM states:
  - IDLE (enable=0): an=FF, seg=7F, dp=1; prescaler=0, digit_idx=0.
  - GUARD (prescaler<GUARD): an=FF.
  - DRIVE (prescaler>=GUARD): an bit digit_idx=0, others 1; seg/dp from the active buffer.
- Transitions:
  - IDLE->GUARD on enable=1, starting slot 0.
  - GUARD->DRIVE when prescaler reaches GUARD.
  - DRIVE->GUARD at slot end (prescaler==REFRESH_DIV-1): prescaler->0; digit_idx increments, wrapping NUM_DIGITS-1->0.
  - Any state->IDLE on the next edge after enable=0, including mid-slot.
- frame_done:
  - Asserted for exactly the first cycle of slot 0 after a wrap.
  - Also asserted on the first slot 0 after leaving IDLE.
- Double buffering:
  - update=1 loads value/dp_in into the pending buffer and sets value_pending.
  - On the frame boundary edge (slot-end with digit_idx=NUM_DIGITS-1), if value_pending=1, pending is copied to active. value_pending is cleared unless update is also high that cycle.
  - update coincident with the boundary: the old pending goes to active; the new data lands in pending; value_pending stays 1.
  - Multiple updates within one frame: last one wins.
  - In IDLE, a pending update transfers immediately to active.
- Leading-zero blanking:
  - When lz_en=1, digit i>0 shows blank segments if nibbles NUM_DIGITS-1..i of active are all zero.
  - Digit 0 is never blanked.
  - dp still follows dp_in for blanked digits.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.

Test Plan:
- Bench params: NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
- Reset then enable=1, idle buffers: cycle pattern per slot is an=FF for 1 cycle then an=E,D,B,7 (low nibble) for 3 cycles each; seg=0000001; frame_done pulses every 16 cycles.
- update with value=0x00A8, dp_in=0010, mid-frame: value_pending=1 until the frame boundary. Next frame shows digit0 seg=0000000, digit1 seg=0001000 with dp=0, digits 2..3 seg=0000001; value_pending=0.
- Same value with lz_en=1: digits 2,3 seg=1111111, digits 0,1 unchanged.
- update on the exact boundary cycle while an earlier update is pending: the earlier value is displayed next frame, the later one the frame after; value_pending stays 1 across the boundary.
- enable dropped mid-DRIVE on digit 2: next edge an=FF, seg=7F, digit_idx=0. Re-enable: slot 0 starts with the guard cycle and frame_done=1.
- Assert rst mid-slot: outputs go to their reset values immediately (asynchronously, without waiting for a clk edge); active buffer reads 0 after release.
